// File: rtl/piso_stream_ctrl.sv
// piso_stream_ctrl: valid/ready sequencer around a parallel-in/serial-out word memory.
// Vectors are accepted on vec_*, then presented word by word on ser_* with a last flag.

// Parallel-in / serial-out word store: load captures all words, en shifts toward word 0.
module piso_mem #(
  parameter int unsigned IWIDTH  = 10,
  parameter int unsigned NINPUTS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        en,
  input  logic [IWIDTH*NINPUTS-1:0]   in,
  output logic [IWIDTH-1:0]           out
);

  logic [IWIDTH-1:0] mem [NINPUTS];

  // Word storage: load has priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NINPUTS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NINPUTS; i++) mem[i] <= in[i*IWIDTH +: IWIDTH];
    end else if (en) begin
      for (int i = 0; i < NINPUTS - 1; i++) mem[i] <= mem[i+1];
    end
  end

  assign out = mem[0];

endmodule

module piso_stream_ctrl #(
  parameter int unsigned IWIDTH  = 10,
  parameter int unsigned NINPUTS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vec_valid,
  output logic                        vec_ready,
  input  logic [IWIDTH*NINPUTS-1:0]   vec_data,
  input  logic                        flush,
  output logic                        ser_valid,
  input  logic                        ser_ready,
  output logic [IWIDTH-1:0]           ser_data,
  output logic                        ser_last,
  output logic                        busy,
  output logic [15:0]                 vec_count
);

  localparam int unsigned CW       = $clog2(NINPUTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NINPUTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0]   count_q, count_next;
  logic          accept, beat, load, en;

  // State, word index and completed-vector counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      count_q <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      count_q <= count_next;
    end
  end

  // Handshakes, memory control and next-state; reset and flush gate the control outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_next = count_q;
    vec_ready  = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    beat       = 1'b0;
    load       = 1'b0;
    en         = 1'b0;

    unique case (state)
      IDLE: begin
        vec_ready = 1'b1;
      end
      STREAM: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_last  = (cnt == LAST_IDX);
        vec_ready = ser_last & ser_ready;
      end
    endcase

    if (flush || rst) vec_ready = 1'b0;
    if (rst) begin
      ser_valid = 1'b0;
      ser_last  = 1'b0;
      busy      = 1'b0;
    end

    accept = vec_valid & vec_ready;
    beat   = ser_valid & ser_ready;
    load   = accept;
    en     = beat & ~ser_last & ~flush;

    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state == IDLE) begin
      if (accept) begin
        state_next = STREAM;
        cnt_next   = '0;
      end
    end else if (beat) begin
      if (!ser_last) begin
        cnt_next = CW'(cnt + 1'b1);
      end else begin
        count_next = 16'(count_q + 16'd1);
        cnt_next   = '0;
        state_next = accept ? STREAM : IDLE;
      end
    end
  end

  piso_mem #(.IWIDTH(IWIDTH), .NINPUTS(NINPUTS)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (en),
    .in   (vec_data),
    .out  (ser_data)
  );

  assign vec_count = count_q;

endmodule

// File: tb/tb_piso_stream_ctrl.sv
// Bench for piso_stream_ctrl: scoreboard of expected serial words plus per-scenario checks.
module tb_piso_stream_ctrl;

  localparam int unsigned IWIDTH  = 10;
  localparam int unsigned NINPUTS = 8;
  localparam int unsigned VW      = IWIDTH * NINPUTS;

  logic              clk = 1'b0;
  logic              rst;
  logic              vec_valid;
  logic              vec_ready;
  logic [VW-1:0]     vec_data;
  logic              flush;
  logic              ser_valid;
  logic              ser_ready;
  logic [IWIDTH-1:0] ser_data;
  logic              ser_last;
  logic              busy;
  logic [15:0]       vec_count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_count  = '0;
  logic [IWIDTH:0] sb[$];

  piso_stream_ctrl #(.IWIDTH(IWIDTH), .NINPUTS(NINPUTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .flush     (flush),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_data  (ser_data),
    .ser_last  (ser_last),
    .busy      (busy),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  // Every consumed word is checked against the scoreboard in order.
  always @(negedge clk) begin : monitor
    logic [IWIDTH:0] e;
    if (!rst && ser_valid && ser_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL beat_unexpected: got last=%0b data=%0d, none expected", ser_last, ser_data);
      end else begin
        e = sb.pop_front();
        if ({ser_last, ser_data} !== e) begin
          mismatched++;
          $display("FAIL beat_data: got last=%0b data=%0d, want last=%0b data=%0d",
                   ser_last, ser_data, e[IWIDTH], e[IWIDTH-1:0]);
        end
      end
    end
  end

  task automatic make_vec(input int base, input int step, output logic [VW-1:0] v);
    for (int k = 0; k < NINPUTS; k++) v[k*IWIDTH +: IWIDTH] = IWIDTH'(base + step * k);
  endtask

  task automatic push_vec(input logic [VW-1:0] v);
    for (int k = 0; k < NINPUTS; k++) sb.push_back({1'(k == NINPUTS - 1), v[k*IWIDTH +: IWIDTH]});
  endtask

  // Offer a vector until accepted (bounded), return just after the accepting edge.
  task automatic send_vec(input logic [VW-1:0] v);
    bit ok = 0;
    vec_valid = 1'b1;
    vec_data  = v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vec_ready) begin ok = 1; break; end
      if (i < 19) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept_timeout: vec_ready=%0b, want 1 within 20 cycles", vec_ready);
    end else push_vec(v);
  endtask

  // Run n cycles expecting a valid word on each.
  task automatic run_valid(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compared++;
      if (ser_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_valid[%0d]: ser_valid=%0b, want 1", i, ser_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    compared++;
    if ({ser_valid, busy, vec_ready, vec_count} !== {1'b0, 1'b0, 1'b1, exp_count}) begin
      mismatched++;
      $display("FAIL %s: valid=%0b busy=%0b ready=%0b count=%0d, want 0 0 1 %0d",
               name, ser_valid, busy, vec_ready, vec_count, exp_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vec_valid = 1'b0; vec_data = '0; flush = 1'b0; ser_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({vec_ready, ser_valid, ser_last, busy, vec_count} !== 20'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b last=%0b busy=%0b count=%0d, want all 0",
               vec_ready, ser_valid, ser_last, busy, vec_count);
    end
    rst = 1'b0;
    check_idle("reset_release");
  endtask

  task automatic test_basic();
    logic [VW-1:0] v;
    ser_ready = 1'b1;
    make_vec(1, 1, v);
    send_vec(v);
    for (int i = 0; i < NINPUTS; i++) begin
      @(negedge clk);
      compared++;
      if ({ser_valid, ser_last} !== {1'b1, 1'(i == NINPUTS - 1)}) begin
        mismatched++;
        $display("FAIL basic_flags[%0d]: valid=%0b last=%0b, want 1 %0b", i, ser_valid, ser_last,
                 i == NINPUTS - 1);
      end
      @(posedge clk); #1;
    end
    exp_count++;
    check_idle("basic_done");
  endtask

  task automatic test_stall();
    logic [VW-1:0] v;
    int pat[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    make_vec(8, -1, v);
    send_vec(v);
    for (int i = 0; i < 10; i++) begin
      ser_ready = pat[i][0];
      @(negedge clk);
      if (pat[i] == 0) begin
        compared++;
        if ({ser_valid, ser_data, dut.en} !== {1'b1, 10'd6, 1'b0}) begin
          mismatched++;
          $display("FAIL stall_hold[%0d]: valid=%0b data=%0d en=%0b, want 1 6 0", i, ser_valid,
                   ser_data, dut.en);
        end
      end
      @(posedge clk); #1;
    end
    ser_ready = 1'b1;
    exp_count++;
    check_idle("stall_done");
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] a, b;
    ser_ready = 1'b1;
    make_vec(1, 1, a);
    make_vec(1023, 0, b);
    send_vec(a);
    vec_valid = 1'b1;
    vec_data  = b;
    push_vec(b);
    for (int i = 0; i < 2 * NINPUTS; i++) begin
      @(negedge clk);
      compared++;
      if (ser_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_valid[%0d]: ser_valid=%0b, want 1", i, ser_valid);
      end
      if (i == NINPUTS - 1) begin
        compared++;
        if ({vec_ready, dut.load} !== 2'b11) begin
          mismatched++;
          $display("FAIL b2b_accept: ready=%0b load=%0b, want 1 1", vec_ready, dut.load);
        end
      end
      @(posedge clk); #1;
      if (i == NINPUTS - 1) vec_valid = 1'b0;
    end
    exp_count += 2;
    check_idle("b2b_done");
  endtask

  task automatic test_flush();
    logic [VW-1:0] v;
    ser_ready = 1'b1;
    make_vec(1, 1, v);
    send_vec(v);
    run_valid(3);
    flush = 1'b1;
    @(negedge clk);
    compared++;
    if ({ser_valid, vec_ready, dut.load, dut.en} !== 4'b1000) begin
      mismatched++;
      $display("FAIL flush_cycle: valid=%0b ready=%0b load=%0b en=%0b, want 1 0 0 0", ser_valid,
               vec_ready, dut.load, dut.en);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    check_idle("flush_idle");
    send_vec(v);
    run_valid(NINPUTS);
    exp_count++;
    check_idle("flush_restream");
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] v;
    ser_ready = 1'b1;
    make_vec(11, 3, v);
    send_vec(v);
    run_valid(4);
    rst = 1'b1;
    #1;
    compared++;
    if ({vec_ready, ser_valid, ser_last, busy, dut.load, dut.en, vec_count} !== 22'd0) begin
      mismatched++;
      $display("FAIL reset_async: ready=%0b valid=%0b last=%0b busy=%0b load=%0b en=%0b count=%0d, want all 0",
               vec_ready, ser_valid, ser_last, busy, dut.load, dut.en, vec_count);
    end
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = '0;
    check_idle("reset_mid_release");
    make_vec(100, 7, v);
    send_vec(v);
    run_valid(NINPUTS);
    exp_count++;
    check_idle("reset_mid_restream");
  endtask

  task automatic test_wrap();
    logic [VW-1:0] v;
    ser_ready = 1'b1;
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    exp_count = 16'hFFFF;
    check_idle("wrap_preload");
    make_vec(5, 9, v);
    send_vec(v);
    run_valid(NINPUTS);
    exp_count = 16'h0000;
    check_idle("wrap_done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wrap();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d words left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
